// File: rtl/fetch_exec_core.sv
// Byte-RAM program sequencer: FETCH/READ/EXEC per instruction (3 cycles), float ops offloaded over start/done.
// No backpressure: the host loads RAM only while idle; the float unit stalls the core in WAITF up to FOP_TIMEOUT cycles.
module fetch_exec_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int RAMSIZE     = 256,
  parameter int NREGS       = 16,
  parameter int FOP_TIMEOUT = 64,
  localparam int AW = $clog2(RAMSIZE),
  localparam int RW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [7:0]            load_data,
  input  logic                  start,
  output logic [AW-1:0]         ipointer,
  output logic [7:0]            opcode,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] debug,
  input  logic [RW-1:0]         dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_reg,
  output logic                  fop_start,
  output logic [1:0]            fop_op,
  output logic [DATA_WIDTH-1:0] fop_a,
  output logic [DATA_WIDTH-1:0] fop_b,
  input  logic                  fop_done,
  input  logic [DATA_WIDTH-1:0] fop_result
);

  localparam int CW = $clog2(FOP_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, READ, EXEC, WAITF, HALT} state_t;

  state_t                state;
  logic [7:0]            ram [RAMSIZE];
  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [RW-1:0]         regSel;
  logic [15:0]           imm;
  logic [31:0]           ramWord;
  logic [DATA_WIDTH-1:0] regVal;
  logic [DATA_WIDTH-1:0] srcVal;
  logic [CW-1:0]         waitCnt;

  logic [AW-1:0] addr;
  logic [RW-1:0] srcSel;
  logic          addrFault;
  logic          execFault;
  logic          storeEn;
  logic [31:0]   storeWord;

  assign addr      = imm[AW-1:0];
  assign srcSel    = imm[RW-1:0];
  // A word access must fit entirely below RAMSIZE; it never wraps.
  assign addrFault = ({1'b0, addr} + (AW+1)'(3)) >= (AW+1)'(RAMSIZE);
  assign execFault = (opcode > 8'd11) ||
                     (((opcode == 8'd2) || (opcode == 8'd3)) && addrFault);
  assign storeEn   = (state == EXEC) && (opcode == 8'd3) && !addrFault;
  assign storeWord = 32'(regVal);
  assign dbg_reg   = regs[dbg_sel];

  // RAM has no reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && load_en)
      ram[load_addr] <= load_data;
    if (storeEn) begin
      ram[addr]          <= storeWord[7:0];
      ram[addr + AW'(1)] <= storeWord[15:8];
      ram[addr + AW'(2)] <= storeWord[23:16];
      ram[addr + AW'(3)] <= storeWord[31:24];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ipointer  <= '0;
      opcode    <= '0;
      regSel    <= '0;
      imm       <= '0;
      ramWord   <= '0;
      regVal    <= '0;
      srcVal    <= '0;
      waitCnt   <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      debug     <= '0;
      fop_start <= 1'b0;
      fop_op    <= '0;
      fop_a     <= '0;
      fop_b     <= '0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      fop_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            ipointer <= '0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          opcode <= ram[ipointer];
          regSel <= ram[ipointer + AW'(1)][RW-1:0];
          imm    <= {ram[ipointer + AW'(3)], ram[ipointer + AW'(2)]};
          state  <= READ;
        end
        READ: begin
          ramWord <= {ram[addr + AW'(3)], ram[addr + AW'(2)],
                      ram[addr + AW'(1)], ram[addr]};
          regVal  <= regs[regSel];
          srcVal  <= regs[srcSel];
          state   <= EXEC;
        end
        EXEC: begin
          if (execFault) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            state    <= FETCH;
            ipointer <= ipointer + AW'(4);
            case (opcode)
              8'd1: regs[regSel] <= DATA_WIDTH'(imm);
              8'd2: regs[regSel] <= DATA_WIDTH'(ramWord);
              8'd4: regs[regSel] <= regVal + srcVal;
              8'd5: debug <= regVal;
              8'd6, 8'd7, 8'd8: begin
                fop_start <= 1'b1;
                fop_op    <= 2'(opcode - 8'd6);
                fop_a     <= regVal;
                fop_b     <= srcVal;
                waitCnt   <= '0;
                ipointer  <= ipointer;
                state     <= WAITF;
              end
              8'd9:  ipointer <= addr;
              8'd10: if (regVal == '0) ipointer <= addr;
              8'd11: begin
                ipointer <= ipointer;
                state    <= HALT;
                busy     <= 1'b0;
                halted   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        WAITF: begin
          if (fop_done) begin
            regs[regSel] <= fop_result;
            ipointer     <= ipointer + AW'(4);
            state        <= FETCH;
          end else if (waitCnt == CW'(FOP_TIMEOUT - 1)) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        HALT: begin
          if (start) begin
            state    <= FETCH;
            ipointer <= '0;
            busy     <= 1'b1;
            halted   <= 1'b0;
            fault    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_exec_core.sv
// Directed bench for fetch_exec_core: hand-assembled programs, a behavioural float unit, hand-computed results.
module tb_fetch_exec_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        start = 1'b0;
  logic [7:0]  ipointer;
  logic [7:0]  opcode;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [31:0] debug;
  logic [3:0]  dbg_sel = '0;
  logic [31:0] dbg_reg;
  logic        fop_start;
  logic [1:0]  fop_op;
  logic [31:0] fop_a;
  logic [31:0] fop_b;
  logic        fop_done = 1'b0;
  logic [31:0] fop_result = '0;

  int nChecks = 0;
  int nPass = 0;

  fetch_exec_core dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .ipointer(ipointer), .opcode(opcode),
    .busy(busy), .halted(halted), .fault(fault), .debug(debug),
    .dbg_sel(dbg_sel), .dbg_reg(dbg_reg),
    .fop_start(fop_start), .fop_op(fop_op), .fop_a(fop_a), .fop_b(fop_b),
    .fop_done(fop_done), .fop_result(fop_result)
  );

  always #5 clk = ~clk;

  // Float unit model: answers 5 cycles after fop_start when enabled.
  bit          fopRespond = 1'b0;
  int          fopDelay = 0;
  int          fopStartCycles = 0;
  logic [1:0]  seenOp = '0;
  logic [31:0] seenA = '0;
  logic [31:0] seenB = '0;

  always @(negedge clk) begin
    fop_done = 1'b0;
    if (fopDelay > 0) begin
      fopDelay--;
      if (fopDelay == 0) begin
        fop_done   = 1'b1;
        fop_result = (seenOp == 2'd2 && seenA == 32'd21) ? 32'h41A8_0000 : 32'hDEAD_BEEF;
      end
    end
    if (fop_start) begin
      fopStartCycles++;
      seenOp = fop_op;
      seenA  = fop_a;
      seenB  = fop_b;
      if (fopRespond) fopDelay = 5;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic loadByte(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic writeInstr(input logic [7:0] a, input logic [7:0] op,
                            input logic [7:0] r, input logic [15:0] imm);
    loadByte(a, op);
    loadByte(a + 8'd1, r);
    loadByte(a + 8'd2, imm[7:0]);
    loadByte(a + 8'd3, imm[15:8]);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic runToHalt(output int busyCycles);
    int guard;
    busyCycles = 0;
    guard = 0;
    while (!halted && guard < 2000) begin
      if (busy) busyCycles++;
      tick();
      guard++;
    end
    checkVal("reached_halt", halted, 1'b1);
  endtask

  task automatic readReg(input logic [3:0] r, output logic [31:0] v);
    dbg_sel = r;
    #1;
    v = dbg_reg;
  endtask

  initial begin
    int cyc;
    int guard;
    logic [31:0] v;

    // Reset state
    #12;
    checkVal("rst_ipointer", ipointer, 8'h00);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_halted", halted, 1'b0);
    checkVal("rst_fault", fault, 1'b0);
    checkVal("rst_fop_start", fop_start, 1'b0);
    checkVal("rst_dbg_reg", dbg_reg, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // movi/add/setdebug/halt: 5 instructions, 15 busy cycles
    writeInstr(8'h00, 8'd1, 8'd0, 16'd21);
    writeInstr(8'h04, 8'd1, 8'd1, 16'd35);
    writeInstr(8'h08, 8'd4, 8'd0, 16'd1);
    writeInstr(8'h0C, 8'd5, 8'd0, 16'd0);
    writeInstr(8'h10, 8'd11, 8'd0, 16'd0);
    pulseStart();
    runToHalt(cyc);
    checkVal("add_busy_cycles", cyc, 15);
    checkVal("add_debug", debug, 32'd56);
    checkVal("add_fault", fault, 1'b0);
    checkVal("add_opcode", opcode, 8'd11);
    readReg(4'd0, v);
    checkVal("add_dbg_r0", v, 32'd56);
    readReg(4'd1, v);
    checkVal("add_dbg_r1", v, 32'd35);

    // store/load round trip and little-endian byte order
    doReset();
    loadByte(8'h80, 8'hFF); loadByte(8'h81, 8'hFF);
    loadByte(8'h82, 8'hFF); loadByte(8'h83, 8'hFF);
    loadByte(8'h84, 8'hAB);
    writeInstr(8'h00, 8'd1, 8'd2, 16'h1234);
    writeInstr(8'h04, 8'd3, 8'd2, 16'h0080);
    writeInstr(8'h08, 8'd2, 8'd3, 16'h0080);
    writeInstr(8'h0C, 8'd2, 8'd4, 16'h0081);
    writeInstr(8'h10, 8'd11, 8'd0, 16'd0);
    pulseStart();
    runToHalt(cyc);
    readReg(4'd3, v);
    checkVal("ld_r3", v, 32'h0000_1234);
    readReg(4'd4, v);
    checkVal("ld_r4_bytes", v, 32'hAB00_0012);
    checkVal("ld_fault", fault, 1'b0);

    // int-to-float through a responding float unit
    doReset();
    writeInstr(8'h00, 8'd1, 8'd0, 16'd21);
    writeInstr(8'h04, 8'd8, 8'd0, 16'd0);
    writeInstr(8'h08, 8'd11, 8'd0, 16'd0);
    fopRespond = 1'b1;
    fopStartCycles = 0;
    pulseStart();
    runToHalt(cyc);
    checkVal("fconv_start_cycles", fopStartCycles, 1);
    checkVal("fconv_op", seenOp, 2'd2);
    checkVal("fconv_a", seenA, 32'd21);
    checkVal("fconv_b", seenB, 32'd21);
    checkVal("fconv_busy_cycles", cyc, 9 + 6);
    readReg(4'd0, v);
    checkVal("fconv_r0", v, 32'h41A8_0000);
    checkVal("fconv_fault", fault, 1'b0);

    // silent float unit: timeout after exactly 64 WAITF cycles
    doReset();
    fopRespond = 1'b0;
    pulseStart();
    guard = 0;
    while (!fop_start && guard < 100) begin
      tick();
      guard++;
    end
    checkVal("to_saw_fop_start", fop_start, 1'b1);
    cyc = 0;
    while (!halted && cyc < 200) begin
      tick();
      cyc++;
    end
    checkVal("to_cycles", cyc, 64);
    checkVal("to_fault", fault, 1'b1);
    checkVal("to_busy", busy, 1'b0);
    fopRespond = 1'b1;
    pulseStart();
    checkVal("restart_halted", halted, 1'b0);
    checkVal("restart_fault", fault, 1'b0);
    checkVal("restart_ipointer", ipointer, 8'h00);
    checkVal("restart_busy", busy, 1'b1);
    runToHalt(cyc);
    checkVal("restart_fault_end", fault, 1'b0);

    // jz taken onto an illegal opcode
    doReset();
    writeInstr(8'h00, 8'd1, 8'd1, 16'd0);
    writeInstr(8'h04, 8'd10, 8'd1, 16'h0010);
    writeInstr(8'h08, 8'd11, 8'd0, 16'd0);
    writeInstr(8'h10, 8'hFF, 8'd0, 16'd0);
    pulseStart();
    runToHalt(cyc);
    checkVal("jz_fault", fault, 1'b1);
    checkVal("jz_ipointer", ipointer, 8'h10);
    checkVal("jz_opcode", opcode, 8'hFF);

    // word access boundary: 0xFC is legal, 0xFD faults without writing
    doReset();
    loadByte(8'hFC, 8'h11); loadByte(8'hFD, 8'h22);
    loadByte(8'hFE, 8'h33); loadByte(8'hFF, 8'h44);
    writeInstr(8'h00, 8'd1, 8'd5, 16'd7);
    writeInstr(8'h04, 8'd2, 8'd6, 16'h00FC);
    writeInstr(8'h08, 8'd2, 8'd5, 16'h00FD);
    writeInstr(8'h0C, 8'd11, 8'd0, 16'd0);
    pulseStart();
    runToHalt(cyc);
    readReg(4'd6, v);
    checkVal("bnd_r6", v, 32'h4433_2211);
    readReg(4'd5, v);
    checkVal("bnd_r5_kept", v, 32'd7);
    checkVal("bnd_fault", fault, 1'b1);
    checkVal("bnd_ipointer", ipointer, 8'h08);

    // reset while fop_start is high, then RAM survives reset
    doReset();
    writeInstr(8'h00, 8'd1, 8'd0, 16'd21);
    writeInstr(8'h04, 8'd8, 8'd0, 16'd0);
    fopRespond = 1'b0;
    pulseStart();
    guard = 0;
    while (!fop_start && guard < 100) begin
      tick();
      guard++;
    end
    checkVal("mid_saw_fop_start", fop_start, 1'b1);
    reset = 1'b0;
    #1;
    checkVal("mid_fop_start", fop_start, 1'b0);
    checkVal("mid_busy", busy, 1'b0);
    checkVal("mid_ipointer", ipointer, 8'h00);
    checkVal("mid_opcode", opcode, 8'h00);
    checkVal("mid_fop_op", fop_op, 2'd0);
    checkVal("mid_fop_a", fop_a, 32'h0);
    readReg(4'd0, v);
    checkVal("mid_r0", v, 32'h0);
    #1;
    reset = 1'b1;
    tick();
    loadByte(8'h04, 8'd0);
    writeInstr(8'h08, 8'd5, 8'd0, 16'd0);
    loadByte(8'h0C, 8'd0);
    load_en   = 1'b1;
    load_addr = 8'h0C;
    load_data = 8'd11;
    start     = 1'b1;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    runToHalt(cyc);
    checkVal("keep_debug", debug, 32'd21);
    checkVal("keep_fault", fault, 1'b0);
    checkVal("keep_cycles", cyc, 12);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
